// File: rtl/fetch_controller.sv
// Purpose : walks the PC through instruction fetch, one request outstanding, holds each word for decode.
// Latency : first request 1 cycle after reset release; 3 cycles per instruction minimum (grant, rvalid, accept).
// Backpres: decode stall (inst_ready=0) freezes the held instruction and blocks the next request;
//           grant stall holds imem_req/imem_addr.
// Ports   : clk/reset (sync, active-high); redirect_valid/redirect_pc load a new fetch PC and flush;
//           imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata form the memory port;
//           inst_valid/inst/inst_pc/inst_ready form the decode handshake; pc is the fetch PC register.
module fetch_controller #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic [XLEN-1:0] pc
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] inst_nxt;
    logic [XLEN-1:0] inst_pc_nxt;
    logic            inst_valid_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
            inst_valid <= inst_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        inst_valid_nxt = inst_valid;

        case (state)
            // Redirects are ignored here so reset sequencing always reaches REQ at RESET_PC.
            BOOT: begin
                state_nxt = REQ;
            end

            REQ: begin
                if (redirect_valid) begin
                    pc_nxt         = redirect_pc;
                    inst_valid_nxt = 1'b0;
                    // A request granted in the same cycle is already in flight; its
                    // response must be swallowed before the new address is issued.
                    state_nxt      = imem_gnt ? DRAIN : REQ;
                end else if (imem_gnt) begin
                    state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_nxt         = redirect_pc;
                    inst_valid_nxt = 1'b0;
                    // Response arriving with the redirect completes the transfer, so
                    // nothing is left to drain.
                    state_nxt      = imem_rvalid ? REQ : DRAIN;
                end else if (imem_rvalid) begin
                    inst_nxt       = imem_rdata;
                    inst_pc_nxt    = pc;
                    inst_valid_nxt = 1'b1;
                    pc_nxt         = pc + PC_STEP;
                    state_nxt      = HOLD;
                end
            end

            HOLD: begin
                // A redirect wins over a coincident accept: the held word is dropped
                // without completing the handshake.
                if (redirect_valid) begin
                    pc_nxt         = redirect_pc;
                    inst_valid_nxt = 1'b0;
                    state_nxt      = REQ;
                end else if (inst_ready) begin
                    inst_valid_nxt = 1'b0;
                    state_nxt      = REQ;
                end
            end

            DRAIN: begin
                if (redirect_valid) begin
                    pc_nxt         = redirect_pc;
                    inst_valid_nxt = 1'b0;
                end
                if (imem_rvalid) begin
                    state_nxt = REQ;
                end
            end

            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'd0;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd1;
    localparam int              NCYC     = 3000;

    logic            clk = 1'b0;
    logic            reset;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic [XLEN-1:0] pc;

    always #5 clk = ~clk;

    fetch_controller #(
        .XLEN    (XLEN),
        .RESET_PC(RESET_PC),
        .PC_STEP (PC_STEP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .pc            (pc)
    );

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name, input logic [XLEN-1:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h, no such event was expected (t=%0t)", name, act, $time);
    endtask

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Monitor: each new presentation pops one expected instruction; every cycle it
    // stays valid must still match it.
    initial begin
        bit   prev_v = 1'b0;
        exp_t cur    = '0;
        forever begin
            @(posedge clk);
            #2;
            if (inst_valid === 1'b1) begin
                if (!prev_v) begin
                    if (sb_q.size() == 0) begin
                        flag_fail("unexpected_inst", inst_pc);
                        cur.pc   = inst_pc;
                        cur.word = inst;
                    end else begin
                        cur = sb_q.pop_front();
                    end
                end
                check("inst_pc", inst_pc, cur.pc);
                check("inst", inst, cur.word);
                check("pc_after_fetch", pc, cur.pc + PC_STEP);
            end
            prev_v = (inst_valid === 1'b1);
        end
    end

    // Stimulus, memory responder and reference model.
    initial begin
        bit              pend      = 1'b0;
        int              cnt       = 0;
        logic [XLEN-1:0] pend_addr = '0;
        bit              live      = 1'b0;
        logic [XLEN-1:0] live_addr = '0;
        logic [XLEN-1:0] exp_pc    = RESET_PC;
        bit              f_reset   = 1'b0;
        bit              f_boot    = 1'b0;
        bit              f_present = 1'b0;
        bit              f_hs      = 1'b0;
        bit              f_redir   = 1'b0;
        logic [XLEN-1:0] f_redir_pc = '0;
        int              last_dlv  = -1;
        bit              free;
        bit              boot;
        bit              rv;
        bit              g;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        inst_ready     = 1'b0;

        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            // Free-running window right after the initial reset: always grant,
            // 1-cycle response, decode always ready, no redirects.
            free = (n >= 2 && n < 20);

            // ---- outcome of the previous clock edge ----
            if (f_reset) begin
                check("rst_inst_valid", 32'(inst_valid), 32'd0);
                check("rst_inst", inst, '0);
                check("rst_inst_pc", inst_pc, '0);
                check("rst_pc", pc, RESET_PC);
                check("rst_imem_req", 32'(imem_req), 32'd0);
                check("rst_imem_addr", imem_addr, RESET_PC);
            end
            if (f_boot) begin
                check("first_req", 32'(imem_req), 32'd1);
                check("first_addr", imem_addr, RESET_PC);
            end
            if (f_present) begin
                check("deliver_valid", 32'(inst_valid), 32'd1);
                if (free) begin
                    if (last_dlv >= 0) check("issue_spacing", 32'(n - last_dlv), 32'd3);
                    last_dlv = n;
                end
            end
            if (f_hs) begin
                check("hs_valid_clear", 32'(inst_valid), 32'd0);
                check("hs_next_req", 32'(imem_req), 32'd1);
            end
            if (f_redir) begin
                check("redir_valid_clear", 32'(inst_valid), 32'd0);
                check("redir_pc", pc, f_redir_pc);
                check("redir_addr", imem_addr, f_redir_pc);
            end
            if (imem_req && inst_valid) flag_fail("req_while_holding", imem_addr);

            // ---- drive inputs for the next edge ----
            boot  = f_reset;
            reset = (n < 2) || (!free && ($urandom_range(99) == 0));

            // Single-entry memory: a response already owed (even across a reset)
            // blocks any new grant until it has been returned.
            rv = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    rv   = 1'b1;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            imem_rvalid = rv;
            imem_rdata  = rv ? mem_word(pend_addr) : $urandom();

            g        = imem_req && !pend && (free || ($urandom_range(9) < 6));
            imem_gnt = g;
            if (g) begin
                pend      = 1'b1;
                pend_addr = imem_addr;
                cnt       = free ? 0 : int'($urandom_range(2));
            end

            inst_ready     = free ? 1'b1 : ($urandom_range(9) < 5);
            redirect_valid = 1'b0;
            if (!free && !reset && !boot && ($urandom_range(99) < 7)) begin
                redirect_valid = 1'b1;
                case ($urandom_range(3))
                    0:       redirect_pc = 32'hFFFF_FFFF;
                    1:       redirect_pc = 32'h0000_0040;
                    default: redirect_pc = $urandom();
                endcase
            end

            // ---- reference model: program-order view of fetch ----
            f_reset   = reset;
            f_boot    = 1'b0;
            f_present = 1'b0;
            f_hs      = 1'b0;
            f_redir   = 1'b0;
            if (reset) begin
                exp_pc = RESET_PC;
                live   = 1'b0;
            end else begin
                f_boot = boot;
                if (g) check("fetch_addr", imem_addr, exp_pc);
                if (redirect_valid) begin
                    exp_pc     = redirect_pc;
                    live       = 1'b0;
                    f_redir    = 1'b1;
                    f_redir_pc = redirect_pc;
                end else begin
                    if (rv && live) begin
                        exp_t e;
                        e.pc   = live_addr;
                        e.word = mem_word(live_addr);
                        sb_q.push_back(e);
                        exp_pc    = live_addr + PC_STEP;
                        live      = 1'b0;
                        f_present = 1'b1;
                    end
                    if (g) begin
                        live      = 1'b1;
                        live_addr = imem_addr;
                    end
                    if (inst_valid && inst_ready) f_hs = 1'b1;
                end
            end
        end

        @(negedge clk);
        check("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
